// File: rtl/bram_arbiter.sv
// bram_arbiter
//   Shares one port of the 16-bit dual-port BRAM between two requesters:
//   requester 0 is the CPU load/store path, requester 1 is the pong/video engine.
//   A request/grant handshake accepts one transaction at a time. Each accepted
//   transaction is driven onto the BRAM port for one cycle. Read data is returned
//   to the requester that won, together with a one-cycle valid pulse.
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   rN_req/we/addr/wdata        request from requester N (held until gnt)
//   rN_gnt                      one-cycle pulse: request accepted
//   rN_rvalid / rN_rdata        read data return (rdata holds last value)
//   mem_addr/mem_wdata/mem_we   BRAM port drive (registered)
//   mem_rdata                   BRAM q, valid one clock after address sampled
//
// Build option
//   ARB_ROUND_ROBIN_EN  when defined, a tie goes to the requester that did not
//                       win last. Otherwise requester 0 always wins a tie.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a request; arbitrates and registers the winner
// ACCESS    | mem_* stable; BRAM samples at the closing edge
// READ_WAIT | BRAM q valid; capture into winner's rdata, pulse rvalid

module bram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  last_winner_q, last_winner_d;
  logic                  cur_id_q, cur_id_d;
  logic                  cur_we_q, cur_we_d;
  logic                  r0_gnt_q, r0_gnt_d;
  logic                  r1_gnt_q, r1_gnt_d;
  logic                  r0_rvalid_q, r0_rvalid_d;
  logic                  r1_rvalid_q, r1_rvalid_d;
  logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_WIDTH-1:0] r1_rdata_q, r1_rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  tie_win;
  logic                  win;

  // Winner when both requesters ask in the same IDLE cycle.
  always_comb begin
    tie_win = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    tie_win = ~last_winner_q;
`endif
  end

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    cur_id_d      = cur_id_q;
    cur_we_d      = cur_we_q;
    r0_gnt_d      = 1'b0;
    r1_gnt_d      = 1'b0;
    r0_rvalid_d   = 1'b0;
    r1_rvalid_d   = 1'b0;
    r0_rdata_d    = r0_rdata_q;
    r1_rdata_d    = r1_rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = mem_we_q;
    win           = (r0_req && r1_req) ? tie_win : r1_req;

    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          mem_addr_d    = win ? r1_addr  : r0_addr;
          mem_wdata_d   = win ? r1_wdata : r0_wdata;
          mem_we_d      = win ? r1_we    : r0_we;
          cur_we_d      = win ? r1_we    : r0_we;
          cur_id_d      = win;
          last_winner_d = win;
          r0_gnt_d      = ~win;
          r1_gnt_d      = win;
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        mem_we_d = 1'b0;
        state_d  = cur_we_q ? IDLE : READ_WAIT;
      end
      READ_WAIT: begin
        if (cur_id_q) begin
          r1_rdata_d  = mem_rdata;
          r1_rvalid_d = 1'b1;
        end else begin
          r0_rdata_d  = mem_rdata;
          r0_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_winner_q <= 1'b1;
      cur_id_q      <= 1'b0;
      cur_we_q      <= 1'b0;
      r0_gnt_q      <= 1'b0;
      r1_gnt_q      <= 1'b0;
      r0_rvalid_q   <= 1'b0;
      r1_rvalid_q   <= 1'b0;
      r0_rdata_q    <= '0;
      r1_rdata_q    <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      cur_id_q      <= cur_id_d;
      cur_we_q      <= cur_we_d;
      r0_gnt_q      <= r0_gnt_d;
      r1_gnt_q      <= r1_gnt_d;
      r0_rvalid_q   <= r0_rvalid_d;
      r1_rvalid_q   <= r1_rvalid_d;
      r0_rdata_q    <= r0_rdata_d;
      r1_rdata_q    <= r1_rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
    end
  end

  assign r0_gnt    = r0_gnt_q;
  assign r1_gnt    = r1_gnt_q;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter
//   Self-checking bench for bram_arbiter with a behavioural synchronous BRAM.
//   Read expectations are queued per requester when a read is granted and
//   consumed whenever that requester's rvalid is seen.

module tb_bram_arbiter;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Synchronous-read BRAM port model.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] e0, e1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-data scoreboard.
  always @(negedge clk) begin
    if (r0_rvalid) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL r0_rvalid unexpected: got 1, expected 0");
      end else begin
        e0 = q0.pop_front();
        chk("r0_rdata", 32'(r0_rdata), 32'(e0));
      end
    end
    if (r1_rvalid) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL r1_rvalid unexpected: got 1, expected 0");
      end else begin
        e1 = q1.pop_front();
        chk("r1_rdata", 32'(r1_rdata), 32'(e1));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("reset ctl outs", 32'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we}), 32'h0);
    chk("reset r0_rdata", 32'(r0_rdata), 32'h0);
    chk("reset r1_rdata", 32'(r1_rdata), 32'h0);
    chk("reset mem_addr", 32'(mem_addr), 32'h0);
    chk("reset mem_wdata", 32'(mem_wdata), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_txn(input logic id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
    bit got = 0;
    @(negedge clk);
    if (id) begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wdata; end
    else    begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wdata; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? r1_gnt : r0_gnt) got = 1;
    end
    r0_req = 0; r1_req = 0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL gnt timeout: got no gnt, expected r%0d_gnt", id);
      return;
    end
    chk("other gnt", 32'(id ? r0_gnt : r1_gnt), 32'h0);
    chk("mem_addr", 32'(mem_addr), 32'(addr));
    chk("mem_we", 32'(mem_we), 32'(we));
    if (we) chk("mem_wdata", 32'(mem_wdata), 32'(wdata));
    else if (id) q1.push_back(exp);
    else q0.push_back(exp);
    @(negedge clk);
    chk("gnt width", 32'(id ? r1_gnt : r0_gnt), 32'h0);
    chk("mem_we width", 32'(mem_we), 32'h0);
    if (!we) begin
      chk("rvalid early", 32'(id ? r1_rvalid : r0_rvalid), 32'h0);
      @(negedge clk);
      chk("rvalid latency", 32'(id ? r1_rvalid : r0_rvalid), 32'h1);
      chk("rvalid other", 32'(id ? r0_rvalid : r1_rvalid), 32'h0);
    end
  endtask

  typedef struct {
    logic          id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int c0, c1, ng, g1, j0, exp_id;
    bit got;

    vecs[0] = '{1'b0, 1'b1, 10'd5,    16'h0008, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 10'd5,    16'h0000, 16'h0008};
    vecs[2] = '{1'b1, 1'b1, 10'd510,  16'h0020, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 10'd511,  16'h0012, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 10'd510,  16'h0000, 16'h0020};
    vecs[5] = '{1'b0, 1'b0, 10'd511,  16'h0000, 16'h0012};
    vecs[6] = '{1'b1, 1'b0, 10'd5,    16'h0000, 16'h0008};
    vecs[7] = '{1'b0, 1'b1, 10'd1023, 16'hFFFF, 16'h0000};
    vecs[8] = '{1'b1, 1'b0, 10'd1023, 16'h0000, 16'hFFFF};
    vecs[9] = '{1'b0, 1'b0, 10'd0,    16'h0000, 16'h0009};

    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    @(negedge clk);
    do_reset();

    // Preload address 0, then start from a fresh reset for the tie case.
    do_txn(1'b0, 1'b1, 10'd0, 16'h0009, 16'h0000);
    do_reset();

    // Simultaneous reads of address 0 right after reset.
    @(negedge clk);
    r0_req = 1; r0_we = 0; r0_addr = 10'd0;
    r1_req = 1; r1_we = 0; r1_addr = 10'd0;
    c0 = -1; c1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r0_gnt && r1_gnt) chk("tie both gnt", 32'h1, 32'h0);
      if (r0_gnt) begin c0 = i; r0_req = 0; q0.push_back(16'h0009); end
      if (r1_gnt) begin c1 = i; r1_req = 0; q1.push_back(16'h0009); end
      if (c0 >= 0 && c1 >= 0) break;
    end
    r0_req = 0; r1_req = 0;
    chk("tie r0 first", 32'(c0), 32'h0);
    chk("tie r1 delay", 32'(c1 - c0), 32'h3);
    repeat (4) @(negedge clk);
    chk("tie q drained", 32'(q0.size() + q1.size()), 32'h0);

    for (int i = 0; i < 10; i++)
      do_txn(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Reset in ACCESS of a read: outputs clear at once, no rvalid follows.
    @(negedge clk);
    r0_req = 1; r0_we = 0; r0_addr = 10'd5;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (r0_gnt) got = 1;
    end
    r0_req = 0;
    chk("abort gnt seen", 32'(got), 32'h1);
    do_reset();
    repeat (3) @(negedge clk);
    do_txn(1'b0, 1'b0, 10'd5, 16'h0000, 16'h0008);

    // Requests held through ACCESS/READ_WAIT.
    @(negedge clk);
    r1_req = 1; r1_we = 0; r1_addr = 10'd510;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (r1_gnt) got = 1;
    end
    chk("held r1 gnt seen", 32'(got), 32'h1);
    q1.push_back(16'h0020);
    r0_req = 1; r0_we = 0; r0_addr = 10'd511;
    g1 = 0; j0 = -1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (r1_gnt) g1++;
      if (r0_gnt) begin j0 = j; r0_req = 0; q0.push_back(16'h0012); end
      if (j == 2) r1_req = 0;
    end
    r0_req = 0; r1_req = 0;
    chk("held extra r1 gnt", 32'(g1), 32'h0);
    chk("held r0 gnt cycle", 32'(j0), 32'h3);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("idle mem_addr hold", 32'(mem_addr), 32'd511);
      chk("idle no gnt", 32'({r0_gnt, r1_gnt}), 32'h0);
    end

    // Continuous dual writes, 12 grants.
    do_reset();
    @(negedge clk);
    r0_req = 1; r0_we = 1; r0_addr = 10'd900; r0_wdata = 16'h0A00;
    r1_req = 1; r1_we = 1; r1_addr = 10'd901; r1_wdata = 16'h0B01;
    ng = 0;
    for (int i = 0; i < 100 && ng < 12; i++) begin
      @(negedge clk);
      if (r0_gnt || r1_gnt) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_id = ng % 2;
`else
        exp_id = 0;
`endif
        chk("cont gnt id", 32'(r1_gnt), 32'(exp_id));
        chk("cont both gnt", 32'(r0_gnt & r1_gnt), 32'h0);
        chk("cont mem_addr", 32'(mem_addr), (exp_id != 0) ? 32'd901 : 32'd900);
        ng++;
        if (ng == 12) begin r0_req = 0; r1_req = 0; end
      end
    end
    r0_req = 0; r1_req = 0;
    chk("cont grant count", 32'(ng), 32'd12);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("cont no stray gnt", 32'({r0_gnt, r1_gnt}), 32'h0);
    end

    chk("final q drained", 32'(q0.size() + q1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
